// File: rtl/lbls_tot_event_packer.sv
// Packs the 12-channel LBLS ToT snapshot into 5-word records (header, timestamp, 3 data words) and streams them from an internal FIFO.
// Build option: define LBLS_TOT_ZERO_SUPPRESS_EN to discard events whose hit bitmap is all zero.
module lbls_tot_event_packer #(
    parameter int FIFO_DEPTH_LOG2    = 6,
    parameter int DROP_COUNTER_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          trigger_active,
    input  logic [7:0]                    tot1,
    input  logic [7:0]                    tot2,
    input  logic [7:0]                    tot3,
    input  logic [7:0]                    tot4,
    input  logic [7:0]                    tot5,
    input  logic [7:0]                    tot6,
    input  logic [7:0]                    tot7,
    input  logic [7:0]                    tot8,
    input  logic [7:0]                    tot9,
    input  logic [7:0]                    tot10,
    input  logic [7:0]                    tot11,
    input  logic [7:0]                    tot12,
    input  logic                          clear_counters,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FIFO_DEPTH_LOG2:0]      fifo_words,
    output logic [DROP_COUNTER_WIDTH-1:0] dropped_events,
    output logic                          busy
);

    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_W   = CW'(DEPTH);
    localparam logic [CW-1:0] REC_WORDS = CW'(5);
    localparam logic [DROP_COUNTER_WIDTH-1:0] DROP_MAX = {DROP_COUNTER_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_HDR  = 3'd2,
        ST_TS   = 3'd3,
        ST_D0   = 3'd4,
        ST_D1   = 3'd5,
        ST_D2   = 3'd6
    } state_t;

    function automatic logic [11:0] hit_map(input logic [95:0] tots);
        logic [11:0] m;
        for (int i = 0; i < 12; i++) begin
            m[i] = (tots[8*i +: 8] != 8'h00);
        end
        return m;
    endfunction

    state_t                        state_r;
    logic                          busy_r;
    logic                          prev_trig_r;
    logic [31:0]                   timestamp_r;
    logic [31:0]                   ts_lat_r;
    logic [7:0]                    evn_r;
    logic [7:0]                    evn_lat_r;
    logic [11:0]                   bitmap_r;
    logic [95:0]                   tot_r;
    logic [DROP_COUNTER_WIDTH-1:0] dropped_r;

    logic [31:0]                mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CW-1:0]              mem_count_r;
    logic [CW-1:0]              fifo_words_r;
    logic                       out_valid_r;
    logic [31:0]                out_data_r;

    logic [95:0] tot_all_s;
    logic [11:0] snap_map_s;
    logic        fall_s;
    logic        room_s;
    logic        zero_skip_s;
    logic        evn_inc_s;
    logic        drop_inc_s;
    logic        wr_en_s;
    logic [31:0] wr_data_s;
    logic        pop_s;
    logic        xfer_s;

    assign tot_all_s  = {tot12, tot11, tot10, tot9, tot8, tot7, tot6, tot5, tot4, tot3, tot2, tot1};
    assign snap_map_s = hit_map(tot_all_s);
    assign fall_s     = prev_trig_r & ~trigger_active;
    // Room is judged on current occupancy only; a read in the same cycle is not credited.
    assign room_s     = ((DEPTH_W - fifo_words_r) >= REC_WORDS);
    assign pop_s      = (mem_count_r != CW'(0)) && (!out_valid_r || out_ready);
    assign xfer_s     = out_valid_r & out_ready;

`ifdef LBLS_TOT_ZERO_SUPPRESS_EN
    assign zero_skip_s = (snap_map_s == 12'h000);
`else
    assign zero_skip_s = 1'b0;
`endif

    // Event-number and drop-counter increments for this cycle.
    always_comb begin
        evn_inc_s  = 1'b0;
        drop_inc_s = 1'b0;
        if (state_r == ST_SNAP) begin
            evn_inc_s  = 1'b1;
            drop_inc_s = !zero_skip_s && !room_s;
        end else if ((state_r != ST_IDLE) && fall_s) begin
            evn_inc_s  = 1'b1;
            drop_inc_s = 1'b1;
        end else begin
            evn_inc_s  = 1'b0;
            drop_inc_s = 1'b0;
        end
    end

    // Record word selected by the writing states.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = 32'h0000_0000;
        case (state_r)
            ST_HDR: begin
                wr_en_s   = 1'b1;
                wr_data_s = {8'hEB, evn_lat_r, 4'h0, bitmap_r};
            end
            ST_TS: begin
                wr_en_s   = 1'b1;
                wr_data_s = ts_lat_r;
            end
            ST_D0: begin
                wr_en_s   = 1'b1;
                wr_data_s = tot_r[31:0];
            end
            ST_D1: begin
                wr_en_s   = 1'b1;
                wr_data_s = tot_r[63:32];
            end
            ST_D2: begin
                wr_en_s   = 1'b1;
                wr_data_s = tot_r[95:64];
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Free-running timestamp, event number and saturating drop counter.
    always_ff @(posedge clock) begin
        if (reset || clear_counters) begin
            timestamp_r <= 32'd0;
            evn_r       <= 8'd0;
            dropped_r   <= {DROP_COUNTER_WIDTH{1'b0}};
        end else begin
            timestamp_r <= timestamp_r + 32'd1;
            evn_r       <= evn_r + {7'd0, evn_inc_s};
            if (drop_inc_s && (dropped_r != DROP_MAX)) begin
                dropped_r <= dropped_r + DROP_COUNTER_WIDTH'(1'b1);
            end
        end
    end

    // Packer state machine with trigger-end detection and record latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            prev_trig_r <= 1'b0;
            ts_lat_r    <= 32'd0;
            evn_lat_r   <= 8'd0;
            bitmap_r    <= 12'h000;
            tot_r       <= 96'd0;
        end else begin
            prev_trig_r <= trigger_active;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        ts_lat_r <= clear_counters ? 32'd0 : timestamp_r;
                        state_r  <= ST_SNAP;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                ST_SNAP: begin
                    tot_r     <= tot_all_s;
                    bitmap_r  <= snap_map_s;
                    evn_lat_r <= evn_r + 8'd1;
                    if (zero_skip_s || !room_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HDR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_HDR:  begin state_r <= ST_TS;   busy_r <= 1'b1; end
                ST_TS:   begin state_r <= ST_D0;   busy_r <= 1'b1; end
                ST_D0:   begin state_r <= ST_D1;   busy_r <= 1'b1; end
                ST_D1:   begin state_r <= ST_D2;   busy_r <= 1'b1; end
                ST_D2:   begin state_r <= ST_IDLE; busy_r <= 1'b0; end
                default: begin state_r <= ST_IDLE; busy_r <= 1'b0; end
            endcase
        end
    end

    // FIFO storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // FIFO pointers and the registered output stage; fifo_words counts the output register too.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= {FIFO_DEPTH_LOG2{1'b0}};
            rd_ptr_r     <= {FIFO_DEPTH_LOG2{1'b0}};
            mem_count_r  <= CW'(0);
            fifo_words_r <= CW'(0);
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'd0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
                out_data_r  <= mem_r[rd_ptr_r];
                out_valid_r <= 1'b1;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
            end
            mem_count_r  <= mem_count_r + CW'(wr_en_s) - CW'(pop_s);
            fifo_words_r <= fifo_words_r + CW'(wr_en_s) - CW'(xfer_s);
        end
    end

    assign out_data       = out_data_r;
    assign out_valid      = out_valid_r;
    assign fifo_words     = fifo_words_r;
    assign dropped_events = dropped_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_lbls_tot_event_packer.sv
// Self-checking bench for lbls_tot_event_packer: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed record words.
module tb_lbls_tot_event_packer;

    localparam int LOG2  = 6;
    localparam int DEPTH = 64;
    localparam int DW    = 16;
    localparam int DROP_MAX = (1 << DW) - 1;
`ifdef LBLS_TOT_ZERO_SUPPRESS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          trigger_active = 1'b0;
    logic          clear_counters = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    tot [12];
    logic [31:0]   out_data;
    logic          out_valid;
    logic [LOG2:0] fifo_words;
    logic [DW-1:0] dropped_events;
    logic          busy;

    always #5 clock = ~clock;

    lbls_tot_event_packer #(.FIFO_DEPTH_LOG2(LOG2), .DROP_COUNTER_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .trigger_active(trigger_active),
        .tot1(tot[0]), .tot2(tot[1]), .tot3(tot[2]), .tot4(tot[3]),
        .tot5(tot[4]), .tot6(tot[5]), .tot7(tot[6]), .tot8(tot[7]),
        .tot9(tot[8]), .tot10(tot[9]), .tot11(tot[10]), .tot12(tot[11]),
        .clear_counters(clear_counters), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_words(fifo_words), .dropped_events(dropped_events),
        .busy(busy)
    );

    // Inputs as seen by the DUT at each edge, and the pre-edge output handshake.
    logic        s_reset, s_trig, s_clear, s_ready, p_outv;
    logic [95:0] s_tot;
    logic [31:0] p_outd;
    always @(posedge clock) begin
        s_reset <= reset;
        s_trig  <= trigger_active;
        s_clear <= clear_counters;
        s_ready <= out_ready;
        p_outv  <= out_valid;
        p_outd  <= out_data;
        for (int i = 0; i < 12; i++) s_tot[8*i +: 8] <= tot[i];
    end

    // Reference model state
    bit          m_prev, m_outv, snap_due;
    logic [31:0] m_ts, m_lat_ts, m_outd;
    logic [7:0]  m_evn;
    int          m_drop, busy_left;
    logic [31:0] memq[$];
    logic [31:0] sched[$];
    logic [31:0] got_q[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input int idx, input logic [31:0] exp);
        if (idx < got_q.size()) chk(nm, got_q[idx], exp);
        else begin
            checks++;
            errors++;
            $display("FAIL %s: word %0d never delivered, expected %h", nm, idx, exp);
        end
    endtask

    task automatic model_step();
        int          pre_words;
        bit          fall, was_busy, ev_inc, drop_inc;
        logic [11:0] bm;
        logic [31:0] ts_pre;
        logic [7:0]  evn_pre;
        if (s_reset) begin
            m_prev = 0; m_ts = 0; m_evn = 0; m_drop = 0; busy_left = 0; snap_due = 0;
            sched.delete(); memq.delete(); m_outv = 0; m_outd = 0; m_lat_ts = 0;
            return;
        end
        pre_words = memq.size() + int'(m_outv);
        fall = m_prev && !s_trig;
        ts_pre = m_ts;
        evn_pre = m_evn;
        // consumer side uses only words already stored before this edge
        if (memq.size() > 0 && (!m_outv || s_ready)) begin
            m_outd = memq.pop_front();
            m_outv = 1;
        end else if (m_outv && s_ready) begin
            m_outv = 0;
        end
        if (sched.size() > 0) memq.push_back(sched.pop_front());
        ev_inc = 0; drop_inc = 0;
        was_busy = busy_left > 0;
        if (busy_left > 0) busy_left--;
        if (snap_due) begin
            snap_due = 0;
            ev_inc = 1;
            for (int i = 0; i < 12; i++) bm[i] = (s_tot[8*i +: 8] != 8'h00);
            if (ZS && bm == 12'h000) busy_left = 0;
            else if (DEPTH - pre_words < 5) begin
                drop_inc = 1;
                busy_left = 0;
            end else begin
                sched.push_back({8'hEB, evn_pre + 8'd1, 4'h0, bm});
                sched.push_back(m_lat_ts);
                sched.push_back(s_tot[31:0]);
                sched.push_back(s_tot[63:32]);
                sched.push_back(s_tot[95:64]);
            end
        end else if (fall && was_busy) begin
            ev_inc = 1;
            drop_inc = 1;
        end else if (fall) begin
            m_lat_ts = s_clear ? 32'd0 : ts_pre;
            snap_due = 1;
            busy_left = 6;
        end
        if (s_clear) begin
            m_ts = 0; m_evn = 0; m_drop = 0;
        end else begin
            m_ts = m_ts + 32'd1;
            m_evn = m_evn + {7'd0, ev_inc};
            if (drop_inc && m_drop < DROP_MAX) m_drop++;
        end
        m_prev = s_trig;
    endtask

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (p_outv === 1'b1 && s_ready === 1'b1) got_q.push_back(p_outd);
            model_step();
            if (busy === 1'b1) busy_cnt++;
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_outv});
            chk("out_data", out_data, m_outd);
            chk("fifo_words", 32'(fifo_words), 32'(memq.size() + int'(m_outv)));
            chk("dropped_events", 32'(dropped_events), 32'(m_drop));
            chk("busy", {31'd0, busy}, {31'd0, busy_left > 0});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic rtick();
        out_ready = 1'($urandom_range(0, 1));
        clear_counters = (busy_left == 0) && ($urandom_range(0, 39) == 0);
        tick();
        clear_counters = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trigger_active = 1'b0;
        clear_counters = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 12; i++) tot[i] = v;
    endtask

    // Raise then drop the trigger; returns just after the edge that sees it low (E0).
    task automatic fire();
        clear_counters = 1'b0;
        trigger_active = 1'b1;
        tick();
        trigger_active = 1'b0;
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 400 && fifo_words != 0; i++) tick();
        chk("drain_empty", 32'(fifo_words), 32'd0);
    endtask

    initial begin
        set_all(8'h00);
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_fifo_words", 32'(fifo_words), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single event, fall at timestamp 100
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 12; i++) tot[i] = 8'(8'h11 * (i + 1));
        trigger_active = 1'b1;
        for (int i = 0; i < 300 && m_ts != 32'd100; i++) tick();
        trigger_active = 1'b0;
        tick();
        tick();
        tick();
        chk("t1_valid_e2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid_e3", {31'd0, out_valid}, 32'd1);
        chk("t1_hdr_e3", out_data, 32'hEB01_0FFF);
        repeat (10) tick();
        chk_q("t1_hdr", 0, 32'hEB01_0FFF);
        chk_q("t1_ts", 1, 32'd100);
        chk_q("t1_d0", 2, 32'h4433_2211);
        chk_q("t1_d1", 3, 32'h8877_6655);
        chk_q("t1_d2", 4, 32'hCCBB_AA99);

        // FIFO fill with no reader
        do_reset();
        out_ready = 1'b0;
        set_all(8'h01);
        for (int e = 0; e < 13; e++) begin
            fire();
            repeat (7) tick();
        end
        repeat (4) tick();
        chk("t2_fifo_words", 32'(fifo_words), 32'd60);
        chk("t2_dropped", 32'(dropped_events), 32'd1);
        got_q.delete();
        drain();
        chk("t2_drained", 32'(got_q.size()), 32'd60);
        got_q.delete();
        fire();
        repeat (8) tick();
        chk_q("t2_next_hdr", 0, 32'hEB0E_0FFF);

        // Second fall only 4 cycles after the first
        do_reset();
        out_ready = 1'b1;
        set_all(8'h5A);
        got_q.delete();
        busy_cnt = 0;
        fire();
        trigger_active = 1'b1;
        repeat (3) tick();
        trigger_active = 1'b0;
        tick();
        repeat (12) tick();
        chk("t3_dropped", 32'(dropped_events), 32'd1);
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("t3_words", 32'(got_q.size()), 32'd5);
        chk_q("t3_hdr", 0, 32'hEB01_0FFF);
        chk_q("t3_d2", 4, 32'h5A5A_5A5A);

        // All-zero event
        do_reset();
        out_ready = 1'b1;
        set_all(8'h00);
        got_q.delete();
        fire();
        repeat (10) tick();
`ifdef LBLS_TOT_ZERO_SUPPRESS_EN
        chk("t4_words", 32'(got_q.size()), 32'd0);
        chk("t4_fifo_words", 32'(fifo_words), 32'd0);
`else
        chk("t4_words", 32'(got_q.size()), 32'd5);
        chk_q("t4_hdr", 0, 32'hEB01_0000);
        chk_q("t4_d0", 2, 32'h0000_0000);
`endif

        // Randomized backpressure over 50 events
        do_reset();
        for (int e = 0; e < 50; e++) begin
            for (int i = 0; i < 12; i++)
                tot[i] = ($urandom_range(0, 3) == 0 || e % 10 == 9) ? 8'h00 : 8'($urandom_range(1, 255));
            fire();
            repeat ($urandom_range(3, 11)) rtick();
        end
        repeat (8) tick();
        drain();

        // Reset in the middle of a record (state D0)
        do_reset();
        out_ready = 1'b0;
        set_all(8'h22);
        fire();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_data", out_data, 32'd0);
        chk("t6_fifo_words", 32'(fifo_words), 32'd0);
        chk("t6_dropped", 32'(dropped_events), 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        got_q.delete();
        fire();
        repeat (8) tick();
        chk_q("t6_hdr", 0, 32'hEB01_0FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lbls_tot_event_packer.md
# lbls_tot_event_packer

Downstream stage of the 12-channel LBLS hit bank. Captures the twelve 8-bit time-over-threshold values at the end of each trigger window, then tags them with a 32-bit timestamp and an event number. Packs each event into a fixed 5-word record and buffers records in an internal FIFO. The FIFO drains to the readout path through a valid/ready stream.

## Interface
Parameters:
- FIFO_DEPTH_LOG2, 6, FIFO depth is 2^FIFO_DEPTH_LOG2 32-bit words; legal range 3..10.
- DROP_COUNTER_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- trigger_active  in  1  same trigger window signal that drives the bank; an event ends on its high-to-low transition.
- tot1..tot12  in  8 each  per-channel time-over-threshold from the bank; valid one cycle after trigger_active is first sampled low.
- clear_counters  in  1  synchronous clear of timestamp, event number and drop counter; FIFO contents are kept.
- out_data  out  32  FIFO head word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- fifo_words  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- dropped_events  out  DROP_COUNTER_WIDTH  saturating count of events lost.
- busy  out  1  packer state machine is not in IDLE.

## Operation
- timestamp: 32-bit free-running counter, +1 per clock, wraps at 2^32.
- Trigger end detection: registered copy of trigger_active. fall = prev & ~trigger_active.
- State machine: IDLE -> SNAP -> HDR -> TS -> D0 -> D1 -> D2 -> IDLE.
  - IDLE: on fall, latch timestamp and go to SNAP.
  - SNAP: latch tot1..tot12, compute 12-bit hit bitmap (bit i-1 = tot_i != 0), increment event_number (8-bit, wraps 255->0, increments on every detected event including drops). If the FIFO has fewer than 5 free slots, increment dropped_events and go to IDLE. Otherwise go to HDR.
  - HDR, TS, D0, D1, D2: each writes one word, one per cycle.
- Header word: [31:24]=8'hEB, [23:16]=event_number after increment, [15:12]=0, [11:0]=hit bitmap.
- TS word: latched timestamp.
- Data words: D0={tot4,tot3,tot2,tot1}, D1={tot8..tot5}, D2={tot12..tot9}, with the lowest-numbered channel in the low byte.
- A fall detected while not in IDLE is lost: dropped_events +1, event_number +1, and the current event completes unchanged.
- dropped_events saturates at all-ones.
- A record is never split. The free-slot check is done in SNAP and ignores any read in the same cycle.
- FIFO:
  - Simultaneous read and write in the same cycle are both honoured; occupancy is unchanged.
  - A read from an empty FIFO is impossible, because out_valid is low.
- Handshake: transfer occurs when out_valid & out_ready. While out_valid & ~out_ready, out_data is held stable.

## Timing
- E0: edge at which trigger_active is first sampled low; fall is registered and the timestamp is latched.
- E1: SNAP.
- E2..E6: HDR, TS, D0, D1, D2 written.
- out_valid rises after E3 at the earliest, and the header appears on out_data then: 3 cycles after E0, with out_ready high.
- Minimum trigger-end spacing without loss is 7 cycles.
- Reset values:
  - out_valid=0, out_data=0, fifo_words=0, dropped_events=0, busy=0.
  - timestamp=0, event_number=0, state=IDLE, prev trigger_active=0.
- Reset mid-record discards the partial record and all FIFO contents.
- clear_counters mid-record: the in-flight record keeps its already-latched values. Counters restart from 0 on the next cycle. If clear_counters and fall coincide, the latched timestamp is 0.

## Configuration
- LBLS_TOT_ZERO_SUPPRESS_EN defined: in SNAP, an all-zero bitmap sends the machine to IDLE with no FIFO writes. event_number still increments; dropped_events is unchanged.
- LBLS_TOT_ZERO_SUPPRESS_EN undefined: all-zero events are written as normal 5-word records with bitmap 0.

## Test plan
- Single event, out_ready=1, tot1=8'h11..tot12=8'hCC, fall at timestamp 100:
  - header 32'hEB01_0FFF, TS 32'd100, D0 32'h4433_2211, D1 32'h8877_6655, D2 32'hCCBB_AA99;
  - header on out_data 3 cycles after E0.
- out_ready=0, 13 events with FIFO_DEPTH_LOG2=6:
  - 12 records stored, fifo_words=60, 13th dropped, dropped_events=1;
  - after draining, the next header shows event_number 14.
- Two falls 4 cycles apart: second is dropped (dropped_events=1); first record is intact; busy is high for 6 cycles.
- All tot=0:
  - with LBLS_TOT_ZERO_SUPPRESS_EN, no words are written and fifo_words stays 0;
  - without it, header 32'hEB01_0000 plus 4 further words.
- Backpressure: toggle out_ready randomly over 50 events. Every word appears exactly once, in order, and out_data is stable whenever valid & ~ready.
- Reset asserted at D0 of a record: all outputs return to reset values next cycle, and the next event's header carries event_number 1.
